flow_tracker: RTL
=================

# flow_tracker

Registered, parametrised occupancy counter for the pipeline flow-control path. Each cycle it adds the popcount of an incoming full-bits vector and subtracts the popcount of an outgoing done-bits vector. It also supports a priority load, and saturate-or-wrap behaviour against a configurable capacity. It replaces the combinational 8-bit next-value counter used beside queue stages: it owns the count register and reports free space, full/empty, and sticky error flags to the stage's accept logic.

## Interface
- `WIDTH`, 8: count register width.
- `IN_LANES`, 8: width of `in_bits`. Must satisfy 1..2^WIDTH-1.
- `OUT_LANES`, 8: width of `out_bits`. Must satisfy 1..2^WIDTH-1.
- `CAPACITY`, 255: maximum legal count. Must satisfy 1..2^WIDTH-1.
- `SATURATE`, 1: 1 = clamp at the bounds; 0 = wrap modulo CAPACITY+1.

- `clk` in 1: the single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `load_en` in 1: load `load_value` into the count. Highest priority.
- `load_value` in WIDTH: the value loaded when `load_en` is high.
- `inc_en` in 1: qualifies `in_bits`.
- `in_bits` in [0:IN_LANES-1]: per-lane arrival bits.
- `dec_en` in 1: qualifies `out_bits`.
- `out_bits` in [0:OUT_LANES-1]: per-lane departure bits.
- `clear_err` in 1: clears the sticky error flags.
- `count` out WIDTH: registered occupancy.
- `next_count` out WIDTH: combinational value that `count` takes at the next edge.
- `free` out WIDTH: CAPACITY - `count`. Registered-derived.
- `empty` out 1: `count` == 0.
- `full` out 1: `count` == CAPACITY.
- `can_accept` out 1: `free` >= IN_LANES, i.e. a full-width arrival fits.
- `overflow` out 1: sticky error flag for an upper-bound violation.
- `underflow` out 1: sticky error flag for a lower-bound violation.

## Operation
- `pin` = popcount(`in_bits`) when `inc_en` is high, else 0.
- `pout` = popcount(`out_bits`) when `dec_en` is high, else 0.
- Raw sum `s` = `count` + `pin` - `pout`. Compute it signed in WIDTH+2 bits, so no intermediate overflow is possible.
- Next-count priority:
  - If `load_en`: next = min(`load_value`, CAPACITY). If `load_value` > CAPACITY, set `overflow`. `inc_en` and `dec_en` are ignored that cycle.
  - Else if `s` > CAPACITY: SATURATE=1 gives next = CAPACITY; SATURATE=0 gives next = `s` - (CAPACITY+1). Either way, set `overflow`.
  - Else if `s` < 0: SATURATE=1 gives next = 0; SATURATE=0 gives next = `s` + (CAPACITY+1). Either way, set `underflow`.
  - Else next = `s`.
- Simultaneous increment and decrement are netted first; only the net result is checked against the bounds. Example: `count` = CAPACITY, `pin` = 3, `pout` = 3 gives no error.
- Sticky flags: a flag sets on the edge after its error condition. `clear_err` clears both flags, but a new error in the same cycle wins (the flag stays or becomes 1).
- `free`, `empty`, `full` and `can_accept` are decoded from the registered `count` only. They are glitch-free relative to the current cycle's inputs.

## Timing
- Reset (asynchronous assert, synchronous-safe release): `count` = 0, `overflow` = 0, `underflow` = 0. This gives `free` = CAPACITY, `empty` = 1, `full` = 0, `can_accept` = (CAPACITY >= IN_LANES).
- `next_count` is combinational from the inputs. `count` reflects it one cycle later.
- Flags update on the same edge as `count`.
- Reset asserted mid-operation overrides any pending load, increment or decrement immediately. No flag survives reset.
- Zero-latency path: `next_count` is valid in the same cycle. This preserves the usage pattern of the earlier combinational counter.

## Structure
- Shared package `flow_pkg` holds:
  - `FLOW_MODE_SAT` = 1 and `FLOW_MODE_WRAP` = 0 constants.
  - A `clog2` helper used for the popcount result width.
- Sub-module `popcount #(N)`: a combinational adder tree. It is instantiated twice, once for `in_bits` and once for `out_bits`, with output width clog2(N+1).
- Parameter checks are done with elaboration-time assertions: CAPACITY <= 2^WIDTH-1, and the lane counts are within range.

## Test plan
- Reset, then `inc_en` = 1 with `in_bits` = 8'b1011_0001 for 1 cycle → `count` = 4, `free` = 251, `empty` = 0.
- `count` = 250, SATURATE=1, `in_bits` all 1s (+8) → `count` = 255, `full` = 1, `overflow` = 1. Then `clear_err` → `overflow` = 0.
- SATURATE=0, CAPACITY=15, WIDTH=4, `count` = 2, `out_bits` = 4 ones → `count` = 14, `underflow` = 1.
- `count` = 10 with `load_en`, `load_value` = 3, and `in_bits` = 0xFF at the same time → `count` = 3, no flag. Then `load_value` = 200 with CAPACITY = 100 → `count` = 100, `overflow` = 1.
- `count` = 255 (full), `in_bits` = 5 ones and `out_bits` = 5 ones at the same time → `count` = 255, no flag.
- `reset` asserted asynchronously between edges while `overflow` = 1 and `count` = 77 → `count` = 0 and `overflow` = 0 immediately, before the next edge.

Source files
------------

// File: rtl/flow_pkg.sv
// Shared constants and helpers for the flow_tracker occupancy counter.
package flow_pkg;

    localparam int FLOW_MODE_SAT  = 32'sd1;
    localparam int FLOW_MODE_WRAP = 32'sd0;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 32'sd0;
        v = value - 32'sd1;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/flow_tracker_popcount.sv
// Combinational population count of an N-bit vector; the accumulation
// loop folds into an adder tree.
module popcount
    import flow_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]              bits_i,
    output logic [clog2(N+1)-1:0]     count_o
);

    localparam int PW = clog2(N + 1);

    logic [PW-1:0] acc_s;

    // Sum every lane bit.
    always_comb begin
        acc_s = {PW{1'b0}};
        for (int i = 0; i < N; i++) begin
            acc_s = acc_s + PW'(bits_i[i]);
        end
    end

    assign count_o = acc_s;

endmodule

// File: rtl/flow_tracker.sv
// Registered occupancy counter: adds arrivals, subtracts departures, with
// priority load, saturate-or-wrap bounds and sticky overflow/underflow flags.
module flow_tracker
    import flow_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int IN_LANES  = 8,
    parameter int OUT_LANES = 8,
    parameter int CAPACITY  = 255,
    parameter int SATURATE  = FLOW_MODE_SAT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [WIDTH-1:0]     load_value,
    input  logic                 inc_en,
    input  logic [0:IN_LANES-1]  in_bits,
    input  logic                 dec_en,
    input  logic [0:OUT_LANES-1] out_bits,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     count,
    output logic [WIDTH-1:0]     next_count,
    output logic [WIDTH-1:0]     free,
    output logic                 empty,
    output logic                 full,
    output logic                 can_accept,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int PW_IN  = clog2(IN_LANES + 1);
    localparam int PW_OUT = clog2(OUT_LANES + 1);
    localparam int MAX_W  = (2 ** WIDTH) - 1;

    localparam logic [WIDTH-1:0]        CAP_W  = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0]        LANE_W = WIDTH'(IN_LANES);
    localparam logic signed [WIDTH+1:0] CAP_S  = (WIDTH+2)'(CAPACITY);
    localparam logic signed [WIDTH+1:0] MOD_S  = (WIDTH+2)'(CAPACITY + 1);
    localparam logic signed [WIDTH+1:0] ZERO_S = {(WIDTH+2){1'b0}};

    if (CAPACITY < 1 || CAPACITY > MAX_W) begin : g_bad_capacity
        $error("flow_tracker: CAPACITY must be within 1..2^WIDTH-1");
    end
    if (IN_LANES < 1 || IN_LANES > MAX_W) begin : g_bad_in_lanes
        $error("flow_tracker: IN_LANES must be within 1..2^WIDTH-1");
    end
    if (OUT_LANES < 1 || OUT_LANES > MAX_W) begin : g_bad_out_lanes
        $error("flow_tracker: OUT_LANES must be within 1..2^WIDTH-1");
    end

    logic [PW_IN-1:0]        pc_in_s;
    logic [PW_OUT-1:0]       pc_out_s;
    logic [PW_IN-1:0]        pin_s;
    logic [PW_OUT-1:0]       pout_s;
    logic signed [WIDTH+1:0] sum_s;
    logic [WIDTH-1:0]        count_q;
    logic [WIDTH-1:0]        count_d;
    logic                    ovf_q;
    logic                    ovf_d;
    logic                    unf_q;
    logic                    unf_d;
    logic                    ovf_evt_s;
    logic                    unf_evt_s;

    popcount #(.N(IN_LANES)) u_pc_in (
        .bits_i  (in_bits),
        .count_o (pc_in_s)
    );

    popcount #(.N(OUT_LANES)) u_pc_out (
        .bits_i  (out_bits),
        .count_o (pc_out_s)
    );

    assign pin_s  = inc_en ? pc_in_s  : {PW_IN{1'b0}};
    assign pout_s = dec_en ? pc_out_s : {PW_OUT{1'b0}};

    // Two spare bits keep the netted sum free of intermediate overflow.
    assign sum_s = $signed({2'b00, count_q})
                 + $signed({{(WIDTH+2-PW_IN){1'b0}}, pin_s})
                 - $signed({{(WIDTH+2-PW_OUT){1'b0}}, pout_s});

    // Next count and error events: load first, then bounds on the net sum.
    always_comb begin
        count_d   = count_q;
        ovf_evt_s = 1'b0;
        unf_evt_s = 1'b0;
        if (load_en) begin
            if (load_value > CAP_W) begin
                count_d   = CAP_W;
                ovf_evt_s = 1'b1;
            end else begin
                count_d = load_value;
            end
        end else if (sum_s > CAP_S) begin
            ovf_evt_s = 1'b1;
            if (SATURATE == FLOW_MODE_SAT) begin
                count_d = CAP_W;
            end else begin
                count_d = WIDTH'(sum_s - MOD_S);
            end
        end else if (sum_s < ZERO_S) begin
            unf_evt_s = 1'b1;
            if (SATURATE == FLOW_MODE_SAT) begin
                count_d = {WIDTH{1'b0}};
            end else begin
                count_d = WIDTH'(sum_s + MOD_S);
            end
        end else begin
            count_d = WIDTH'(sum_s);
        end
    end

    // A fresh error beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_evt_s | (ovf_q & ~clear_err);
        unf_d = unf_evt_s | (unf_q & ~clear_err);
    end

    // Count and sticky flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {WIDTH{1'b0}};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count      = count_q;
    assign next_count = count_d;
    assign free       = CAP_W - count_q;
    assign empty      = (count_q == {WIDTH{1'b0}});
    assign full       = (count_q == CAP_W);
    assign can_accept = (free >= LANE_W);
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule
